// File: rtl/sop_eval_pkg.sv
// sop_eval_pkg
// Shared definitions for the approximate-adder sweep checker.
//   state_t       : sweep controller states
//   widths_legal  : operand split / output width consistency check
//   lat_legal     : per-vector hold time must be at least one cycle
package sop_eval_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Inputs split evenly into two operands; the sum needs one carry bit.
   function automatic bit widths_legal(input int n_in, input int n_out);
      return (n_in >= 2) && ((n_in % 2) == 0) && (n_out == (n_in / 2) + 1);
   endfunction

   function automatic bit lat_legal(input int lat);
      return lat >= 1;
   endfunction

endpackage

// File: rtl/sop_exact_ref.sv
// sop_exact_ref
// Combinational golden adder plus absolute-difference unit.
//   stim   [N_IN-1:0]  : vector applied to the circuit under test
//                        (A = low half, B = high half)
//   approx [N_OUT-1:0] : outputs returned by the circuit under test
//   err    [N_OUT-1:0] : |approx - (A + B)|, unsigned, never wraps
module sop_exact_ref
   import sop_eval_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3
) (
   input  logic [N_IN-1:0]  stim,
   input  logic [N_OUT-1:0] approx,
   output logic [N_OUT-1:0] err
);

   localparam int HALF = N_IN / 2;

   logic [HALF-1:0]  op_a;
   logic [HALF-1:0]  op_b;
   logic [N_OUT-1:0] exact;

   assign op_a  = stim[HALF-1:0];
   assign op_b  = stim[N_IN-1:HALF];
   // N_OUT = HALF+1, so the zero-extended sum cannot overflow.
   assign exact = N_OUT'(op_a) + N_OUT'(op_b);
   // Subtract the smaller from the larger so the magnitude stays in N_OUT bits.
   assign err   = (approx >= exact) ? (approx - exact) : (exact - approx);

endmodule

// File: rtl/sop_error_evaluator.sv
// sop_error_evaluator
// Exhaustive sweep checker for a combinational approximate adder.
// Drives every input vector, holds each for LAT cycles, samples the
// circuit outputs and accumulates worst-case and count-of-error results.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : begin a sweep (ignored while busy_o)
//   stim_o        : vector driven to the circuit under test
//   approx_i      : circuit under test outputs
//   busy_o        : sweep in progress
//   done_o        : one-cycle pulse when results are valid
//   pass_o        : max_err_o <= ET
//   max_err_o     : largest absolute error seen
//   err_cnt_o     : vectors with nonzero error
//   fail_vld_o    : some vector exceeded ET
//   first_fail_o  : first vector exceeding ET (0 if none)
module sop_error_evaluator
   import sop_eval_pkg::*;
#(
   parameter int N_IN       = 4,
   parameter int N_OUT      = 3,
   parameter int ET         = 1,
   parameter int LAT        = 1,
   parameter int EARLY_EXIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic [N_IN-1:0]   stim_o,
   input  logic [N_OUT-1:0]  approx_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [N_OUT-1:0]  max_err_o,
   output logic [N_IN:0]     err_cnt_o,
   output logic              fail_vld_o,
   output logic [N_IN-1:0]   first_fail_o
);

   generate
      if (!widths_legal(N_IN, N_OUT)) begin : g_bad_width
         $error("sop_error_evaluator: N_IN must be even and N_OUT must equal N_IN/2+1");
      end
      if (!lat_legal(LAT)) begin : g_bad_lat
         $error("sop_error_evaluator: LAT must be at least 1");
      end
   endgenerate

   localparam int               CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [N_IN-1:0]  STIM_ONE = N_IN'(1);
   localparam logic [N_IN:0]    ECNT_ONE = (N_IN + 1)'(1);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [N_IN-1:0]    stim_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic [N_OUT-1:0]   max_err_q;
   logic [N_IN:0]      err_cnt_q;
   logic               fail_vld_q;
   logic [N_IN-1:0]    first_fail_q;

   logic [N_OUT-1:0]   err;
   logic               over_et;
   logic               accept;
   logic               sample;

   sop_exact_ref #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT)
   ) u_exact_ref (
      .stim   (stim_q),
      .approx (approx_i),
      .err    (err)
   );

   assign over_et = int'(err) > ET;

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      sample  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               accept  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               sample = 1'b1;
               if ((stim_q == '1) || ((EARLY_EXIT != 0) && over_et)) begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         stim_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         max_err_q    <= '0;
         err_cnt_q    <= '0;
         fail_vld_q   <= 1'b0;
         first_fail_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         if (accept) begin
            stim_q       <= '0;
            cnt_q        <= CNT_LOAD;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            max_err_q    <= '0;
            err_cnt_q    <= '0;
            fail_vld_q   <= 1'b0;
            first_fail_q <= '0;
         end else if (state_q == HOLD) begin
            if (!sample) begin
               cnt_q <= cnt_q - CNT_ONE;
            end else begin
               if (err != '0) begin
                  err_cnt_q <= err_cnt_q + ECNT_ONE;
               end
               if (err > max_err_q) begin
                  max_err_q <= err;
               end
               if (over_et && !fail_vld_q) begin
                  fail_vld_q   <= 1'b1;
                  first_fail_q <= stim_q;
               end
               // On the final vector stim_q is left as-is for inspection.
               if (state_d == HOLD) begin
                  stim_q <= stim_q + STIM_ONE;
                  cnt_q  <= CNT_LOAD;
               end
            end
         end else if (state_q == FINISH) begin
            // max_err_q already holds the last sample's contribution here.
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= int'(max_err_q) <= ET;
         end
      end
   end

   assign stim_o       = stim_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign max_err_o    = max_err_q;
   assign err_cnt_o    = err_cnt_q;
   assign fail_vld_o   = fail_vld_q;
   assign first_fail_o = first_fail_q;

endmodule

// File: tb/tb_sop_error_evaluator.sv
// tb_sop_error_evaluator
// Three checker instances (default, early-exit, LAT=3) each driving a
// behavioural approximate adder selected by 'mode':
//   0 = exact sum, 1 = all outputs tied 0, 2 = exact sum with out[0] forced 0.
module tb_sop_error_evaluator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int mode = 0;

   logic       start      [3];
   logic [3:0] stim       [3];
   logic [2:0] approx     [3];
   logic       busy       [3];
   logic       done       [3];
   logic       pass       [3];
   logic [2:0] max_err    [3];
   logic [4:0] err_cnt    [3];
   logic       fail_vld   [3];
   logic [3:0] first_fail [3];

   function automatic logic [2:0] circuit(input logic [3:0] s, input int m);
      logic [2:0] sum;
      sum = {1'b0, s[1:0]} + {1'b0, s[3:2]};
      case (m)
         0:       return sum;
         1:       return 3'd0;
         default: return {sum[2:1], 1'b0};
      endcase
   endfunction

   assign approx[0] = circuit(stim[0], mode);
   assign approx[1] = circuit(stim[1], mode);
   assign approx[2] = circuit(stim[2], mode);

   sop_error_evaluator u_dut (
      .clk(clk), .rst(rst), .start_i(start[0]), .stim_o(stim[0]), .approx_i(approx[0]),
      .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .max_err_o(max_err[0]),
      .err_cnt_o(err_cnt[0]), .fail_vld_o(fail_vld[0]), .first_fail_o(first_fail[0])
   );

   sop_error_evaluator #(.EARLY_EXIT(1)) u_ee (
      .clk(clk), .rst(rst), .start_i(start[1]), .stim_o(stim[1]), .approx_i(approx[1]),
      .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .max_err_o(max_err[1]),
      .err_cnt_o(err_cnt[1]), .fail_vld_o(fail_vld[1]), .first_fail_o(first_fail[1])
   );

   sop_error_evaluator #(.LAT(3)) u_lat (
      .clk(clk), .rst(rst), .start_i(start[2]), .stim_o(stim[2]), .approx_i(approx[2]),
      .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]), .max_err_o(max_err[2]),
      .err_cnt_o(err_cnt[2]), .fail_vld_o(fail_vld[2]), .first_fail_o(first_fail[2])
   );

   typedef struct {
      logic [2:0] max_err;
      logic [4:0] err_cnt;
      logic       pass;
      logic       fail_vld;
      logic [3:0] first_fail;
      logic [3:0] stim;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_all_zero(input int idx, input string tag);
      check({tag, "_stim"},       stim[idx],       0);
      check({tag, "_busy"},       busy[idx],       0);
      check({tag, "_done"},       done[idx],       0);
      check({tag, "_pass"},       pass[idx],       0);
      check({tag, "_max_err"},    max_err[idx],    0);
      check({tag, "_err_cnt"},    err_cnt[idx],    0);
      check({tag, "_fail_vld"},   fail_vld[idx],   0);
      check({tag, "_first_fail"}, first_fail[idx], 0);
   endtask

   // Pulse start, wait (bounded) for done, then pop and compare results.
   task automatic run_sweep(input int idx, input int md, input exp_t e);
      exp_t got;
      int   cyc;
      int   busy_cyc;
      mode = md;
      sb.push_back(e);
      @(negedge clk);
      start[idx] = 1'b1;
      @(posedge clk);
      #1;
      start[idx] = 1'b0;
      check("start_busy", busy[idx], 1);
      check("start_stim", stim[idx], 0);
      cyc      = 0;
      busy_cyc = 1;
      while (done[idx] !== 1'b1 && cyc < 300) begin
         // Restart attempt in the middle of the LAT=3 sweep must be ignored.
         if (idx == 2 && cyc == 10) start[2] = 1'b1;
         @(posedge clk);
         #1;
         start[idx] = 1'b0;
         cyc++;
         if (busy[idx] === 1'b1) busy_cyc++;
         if (idx == 2 && cyc < 48) check("lat3_stim", stim[2], cyc / 3);
      end
      got = sb.pop_front();
      check("done_latency", cyc, got.lat);
      check("busy_cycles",  busy_cyc, got.lat);
      check("max_err",      max_err[idx],    got.max_err);
      check("err_cnt",      err_cnt[idx],    got.err_cnt);
      check("pass",         pass[idx],       got.pass);
      check("fail_vld",     fail_vld[idx],   got.fail_vld);
      check("first_fail",   first_fail[idx], got.first_fail);
      check("final_stim",   stim[idx],       got.stim);
      @(posedge clk);
      #1;
      check("done_one_cycle", done[idx],    0);
      check("idle_busy",      busy[idx],    0);
      check("hold_err_cnt",   err_cnt[idx], got.err_cnt);
      check("hold_stim",      stim[idx],    got.stim);
   endtask

   task automatic count_done(input int idx, input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #1;
         if (done[idx] === 1'b1) n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   w;
      exp_t e_exact;
      exp_t e_zero;
      exp_t e_lsb0;
      exp_t e_early;
      exp_t e_lat3;

      e_exact = '{3'd0, 5'd0,  1'b1, 1'b0, 4'd0, 4'd15, 17};
      e_zero  = '{3'd6, 5'd15, 1'b0, 1'b1, 4'd2, 4'd15, 17};
      e_lsb0  = '{3'd1, 5'd8,  1'b1, 1'b0, 4'd0, 4'd15, 17};
      e_early = '{3'd2, 5'd2,  1'b0, 1'b1, 4'd2, 4'd2,  4};
      e_lat3  = '{3'd0, 5'd0,  1'b1, 1'b0, 4'd0, 4'd15, 49};

      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero(0, "reset");
      @(negedge clk);
      rst = 1'b0;

      // Exact circuit: no error, pass.
      run_sweep(0, 0, e_exact);
      // Outputs tied low: worst error at 3+3, first failure at vector 2.
      run_sweep(0, 1, e_zero);
      // LSB stuck at 0: off by one on the 8 odd sums, still within ET.
      run_sweep(0, 2, e_lsb0);
      // Early exit stops on vector 2 and leaves it on stim.
      run_sweep(1, 1, e_early);
      // LAT=3 with an ignored mid-sweep start.
      run_sweep(2, 0, e_lat3);
      count_done(2, 60, n);
      check("lat3_single_done", n, 0);

      // Reset in the middle of a sweep.
      mode = 0;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      w = 0;
      while (stim[0] !== 4'd7 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("reach_vector7", stim[0], 7);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero(0, "midreset");
      @(negedge clk);
      rst = 1'b0;
      count_done(0, 25, n);
      check("no_done_after_reset", n, 0);
      check("idle_after_reset", busy[0], 0);
      run_sweep(0, 0, e_exact);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
